// File: rtl/serial_operand_tx.sv
// Bit-serial transmitter: latches an A/B word pair and shifts both out in lockstep with framing strobes.
// Latency: bit i on a/b after accept edge k+i; done after k+WIDTH; ready again after k+WIDTH+GAP_CYCLES.
module serial_operand_tx #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   output logic             a,
   output logic             b,
   output logic             frame,
   output logic             first_bit,
   output logic             last_bit,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + GAP_CYCLES + 1);
   localparam logic [CW-1:0] WIDTH_C    = CW'(WIDTH);
   localparam logic [CW-1:0] LAST_C     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] GAP_LAST_C = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_a_q, sr_a_d, sr_b_q, sr_b_d;
   logic             a_q, a_d, b_q, b_d;
   logic             frame_q, frame_d, first_q, first_d, last_q, last_d;
   logic             done_q, done_d, ready_q, ready_d;

   function automatic logic head(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_a_d  = sr_a_q;
      sr_b_d  = sr_b_q;
      a_d     = 1'b0;
      b_d     = 1'b0;
      frame_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = ready_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (load_valid && ready_q) begin
               // Bit 0 goes straight to the output flops; the rest waits in the shift registers.
               state_d = SHIFT;
               a_d     = head(a_word);
               b_d     = head(b_word);
               sr_a_d  = advance(a_word);
               sr_b_d  = advance(b_word);
               frame_d = 1'b1;
               first_d = 1'b1;
               cnt_d   = CW'(1);
               ready_d = 1'b0;
            end
         end
         SHIFT: begin
            if (cnt_q != WIDTH_C) begin
               a_d     = head(sr_a_q);
               b_d     = head(sr_b_q);
               sr_a_d  = advance(sr_a_q);
               sr_b_d  = advance(sr_b_q);
               frame_d = 1'b1;
               last_d  = (cnt_q == LAST_C);
               cnt_d   = cnt_q + 1'b1;
            end else begin
               done_d = 1'b1;
               cnt_d  = '0;
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST_C) begin
               state_d = IDLE;
               ready_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_a_q  <= '0;
         sr_b_q  <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         frame_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_a_q  <= sr_a_d;
         sr_b_q  <= sr_b_d;
         a_q     <= a_d;
         b_q     <= b_d;
         frame_q <= frame_d;
         first_q <= first_d;
         last_q  <= last_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign a          = a_q;
   assign b          = b_q;
   assign frame      = frame_q;
   assign first_bit  = first_q;
   assign last_bit   = last_q;
   assign done       = done_q;
   assign load_ready = ready_q;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench for serial_operand_tx: three instances cover MSB-first, LSB-first and a 2-cycle gap.
module tb_serial_operand_tx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic       m_lv = 1'b0, m_lr, m_a, m_b, m_fr, m_fb, m_lb, m_dn;
   logic [7:0] m_aw = 8'h00, m_bw = 8'h00;
   logic       l_lv = 1'b0, l_lr, l_a, l_b, l_fr, l_fb, l_lb, l_dn;
   logic [7:0] l_aw = 8'h00, l_bw = 8'h00;
   logic       g_lv = 1'b0, g_lr, g_a, g_b, g_fr, g_fb, g_lb, g_dn;
   logic [7:0] g_aw = 8'h00, g_bw = 8'h00;

   serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset), .load_valid(m_lv), .load_ready(m_lr),
      .a_word(m_aw), .b_word(m_bw), .a(m_a), .b(m_b), .frame(m_fr),
      .first_bit(m_fb), .last_bit(m_lb), .done(m_dn));

   serial_operand_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1)) u_lsb (
      .clk(clk), .reset(reset), .load_valid(l_lv), .load_ready(l_lr),
      .a_word(l_aw), .b_word(l_bw), .a(l_a), .b(l_b), .frame(l_fr),
      .first_bit(l_fb), .last_bit(l_lb), .done(l_dn));

   serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .reset(reset), .load_valid(g_lv), .load_ready(g_lr),
      .a_word(g_aw), .b_word(g_bw), .a(g_a), .b(g_b), .frame(g_fr),
      .first_bit(g_fb), .last_bit(g_lb), .done(g_dn));

   // Reference bit-serial magnitude comparator, MSB first, cleared while frame is low.
   logic cmp_gt = 1'b0, cmp_eq = 1'b1, cmp_lt = 1'b0;
   always @(posedge clk) begin
      if (!m_fr) begin
         cmp_gt <= 1'b0; cmp_eq <= 1'b1; cmp_lt <= 1'b0;
      end else if (cmp_eq && (m_a != m_b)) begin
         cmp_eq <= 1'b0; cmp_gt <= m_a; cmp_lt <= m_b;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m_lv = 1'b1; l_lv = 1'b1; g_lv = 1'b1;
      m_aw = 8'hFF; m_bw = 8'hFF; l_aw = 8'hFF; l_bw = 8'hFF; g_aw = 8'hFF; g_bw = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         tests++;
         if ({m_a, m_b, m_fr, m_fb, m_lb, m_dn, m_lr} !== 7'b0000001) begin
            fails++; $display("FAIL reset_msb cyc%0d got=%b want=0000001", c, {m_a, m_b, m_fr, m_fb, m_lb, m_dn, m_lr});
         end
         tests++;
         if ({l_a, l_b, l_fr, l_fb, l_lb, l_dn, l_lr} !== 7'b0000001) begin
            fails++; $display("FAIL reset_lsb cyc%0d got=%b want=0000001", c, {l_a, l_b, l_fr, l_fb, l_lb, l_dn, l_lr});
         end
         tests++;
         if ({g_a, g_b, g_fr, g_fb, g_lb, g_dn, g_lr} !== 7'b0000001) begin
            fails++; $display("FAIL reset_gap cyc%0d got=%b want=0000001", c, {g_a, g_b, g_fr, g_fb, g_lb, g_dn, g_lr});
         end
      end
      reset = 1'b0;
      m_lv = 1'b0; l_lv = 1'b0; g_lv = 1'b0;
      tick();
      tests++;
      if ({m_fr, l_fr, g_fr, m_lr, l_lr, g_lr} !== 6'b000111) begin
         fails++; $display("FAIL reset_no_accept got=%b want=000111", {m_fr, l_fr, g_fr, m_lr, l_lr, g_lr});
      end
   endtask

   task automatic test_msb_frame();
      logic [7:0] ea, eb;
      ea = 8'b10100101;  // a sequence, [7] first
      eb = 8'b00111100;
      m_aw = 8'hA5; m_bw = 8'h3C; m_lv = 1'b1;
      tick();
      m_lv = 1'b0; m_aw = 8'h00; m_bw = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if ({m_a, m_b} !== {ea[7-i], eb[7-i]}) begin
            fails++; $display("FAIL msb_bits bit%0d got=%b%b want=%b%b", i, m_a, m_b, ea[7-i], eb[7-i]);
         end
         tests++;
         if ({m_fr, m_fb, m_lb, m_dn, m_lr} !== {1'b1, i == 0, i == 7, 1'b0, 1'b0}) begin
            fails++; $display("FAIL msb_strobes bit%0d got=%b want=%b", i, {m_fr, m_fb, m_lb, m_dn, m_lr}, {1'b1, i == 0, i == 7, 2'b00});
         end
         if (i < 7) tick();
      end
      tick();
      tests++;
      if ({m_dn, m_fr, m_a, m_b, m_lr} !== 5'b10000) begin
         fails++; $display("FAIL msb_done got=%b want=10000", {m_dn, m_fr, m_a, m_b, m_lr});
      end
      tick();
      tests++;
      if ({m_dn, m_fr, m_lr} !== 3'b001) begin
         fails++; $display("FAIL msb_ready_after_gap got=%b want=001", {m_dn, m_fr, m_lr});
      end
   endtask

   task automatic test_lsb_frame();
      logic [7:0] sa, sb;
      sa = 8'b00000001;  // time-ordered, [0] first
      sb = 8'b10000000;
      l_aw = 8'h01; l_bw = 8'h80; l_lv = 1'b1;
      tick();
      l_lv = 1'b0; l_aw = 8'hFF; l_bw = 8'h00;
      for (int i = 0; i < 8; i++) begin
         tests++;
         if ({l_a, l_b, l_fr, l_fb, l_lb} !== {sa[i], sb[i], 1'b1, i == 0, i == 7}) begin
            fails++; $display("FAIL lsb_bit%0d got=%b want=%b", i, {l_a, l_b, l_fr, l_fb, l_lb}, {sa[i], sb[i], 1'b1, i == 0, i == 7});
         end
         if (i < 7) tick();
      end
      tick();
      tests++;
      if ({l_dn, l_fr, l_a, l_b} !== 4'b1000) begin
         fails++; $display("FAIL lsb_done got=%b want=1000", {l_dn, l_fr, l_a, l_b});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] fa, fb;
      int p;
      fa = 8'h00; fb = 8'h00;
      g_lv = 1'b1;
      for (int t = 0; t < 33; t++) begin
         g_aw = 8'(t * 37 + 5);
         g_bw = ~8'(t * 37 + 5);
         p = t % 11;
         if (p == 0) begin
            fa = g_aw; fb = g_bw;
         end
         tick();
         tests++;
         if ({g_fr, g_fb, g_lb, g_dn, g_lr} !== {p < 8, p == 0, p == 7, p == 8, p == 10}) begin
            fails++; $display("FAIL b2b_strobes t%0d got=%b want=%b", t, {g_fr, g_fb, g_lb, g_dn, g_lr}, {p < 8, p == 0, p == 7, p == 8, p == 10});
         end
         tests++;
         if (p < 8) begin
            if ({g_a, g_b} !== {fa[7-p], fb[7-p]}) begin
               fails++; $display("FAIL b2b_data t%0d got=%b%b want=%b%b", t, g_a, g_b, fa[7-p], fb[7-p]);
            end
         end else if ({g_a, g_b} !== 2'b00) begin
            fails++; $display("FAIL b2b_idle_data t%0d got=%b%b want=00", t, g_a, g_b);
         end
      end
      g_lv = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset_abort();
      int pulses;
      logic [7:0] ga, gb;
      m_aw = 8'hFF; m_bw = 8'hFF; m_lv = 1'b1;
      tick();
      m_lv = 1'b0;
      repeat (3) tick();
      tests++;
      if ({m_fr, m_a} !== 2'b11) begin
         fails++; $display("FAIL abort_pre got=%b want=11", {m_fr, m_a});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if ({m_fr, m_a, m_b, m_fb, m_lb, m_dn, m_lr} !== 7'b0000001) begin
         fails++; $display("FAIL abort_reset got=%b want=0000001", {m_fr, m_a, m_b, m_fb, m_lb, m_dn, m_lr});
      end
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (m_dn || m_fr) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++; $display("FAIL abort_no_done got=%0d want=0", pulses);
      end
      m_aw = 8'h96; m_bw = 8'h69; m_lv = 1'b1;
      tick();
      m_lv = 1'b0;
      ga = 8'h00; gb = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (!m_fr) begin
            fails++; tests++; $display("FAIL abort_clean_frame bit%0d got=0 want=1", i);
         end
         ga = {ga[6:0], m_a};
         gb = {gb[6:0], m_b};
         tick();
      end
      tests++;
      if ({ga, gb} !== 16'h9669) begin
         fails++; $display("FAIL abort_clean_data got=%h want=9669", {ga, gb});
      end
      tests++;
      if (m_dn !== 1'b1) begin
         fails++; $display("FAIL abort_clean_done got=%b want=1", m_dn);
      end
      tick();
   endtask

   task automatic test_comparator();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [2:0] ex [3];  // {gt, eq, lt}
      va[0] = 8'h80; vb[0] = 8'h7F; ex[0] = 3'b100;
      va[1] = 8'h5A; vb[1] = 8'h5A; ex[1] = 3'b010;
      va[2] = 8'h00; vb[2] = 8'h01; ex[2] = 3'b001;
      for (int n = 0; n < 3; n++) begin
         m_aw = va[n]; m_bw = vb[n]; m_lv = 1'b1;
         tick();
         m_lv = 1'b0;
         repeat (8) tick();
         tests++;
         if ({m_dn, cmp_gt, cmp_eq, cmp_lt} !== {1'b1, ex[n]}) begin
            fails++; $display("FAIL cmp%0d got=%b want=%b", n, {m_dn, cmp_gt, cmp_eq, cmp_lt}, {1'b1, ex[n]});
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_msb_frame();
      test_lsb_frame();
      test_back_to_back();
      test_reset_abort();
      test_comparator();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
